// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive host controller.
//   rx_state_e  : controller FSM states
//   ERR_*       : bit positions inside the 3-bit receiver error field
//   ENTRY_W     : FIFO entry width, {err[2:0], data[7:0]}
package uart_rx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAck,
    StRelease
  } rx_state_e;

  localparam int unsigned ERR_PARITY  = 2;
  localparam int unsigned ERR_FRAMING = 1;
  localparam int unsigned ERR_OVERRUN = 0;

  localparam int unsigned ENTRY_W = 11;

endpackage

// File: rtl/rx_byte_fifo.sv
// Synchronous FIFO holding received bytes with their error flags.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   push, wdata  : write request and entry; ignored while full
//   pop          : read request; ignored while empty
//   rdata        : head entry, forced to 0 while empty
//   full, empty  : occupancy flags derived from the registered count
//   level        : current occupancy, 0..DEPTH
module rx_byte_fifo
  import uart_rx_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [ENTRY_W-1:0]         wdata,
  input  logic                       pop,
  output logic [ENTRY_W-1:0]         rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]      wptr_q, rptr_q;
  logic [LW-1:0]      count_q;
  logic               do_push, do_pop;

  assign full    = (count_q == LW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // DEPTH is a power of two, so natural pointer overflow wraps modulo DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Storage needs no reset: reads are masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

  assign rdata = empty ? '0 : mem_q[rptr_q];
  assign level = count_q;

endmodule

// File: rtl/uart_rx_host_ctrl.sv
// Host-side controller for the UART byte receiver. Captures each interrupt's
// byte and error flags into a FIFO, pulses rx_ack back to the receiver and
// offers the buffered bytes to the host over a valid/ready handshake.
// Ports:
//   overSampler           : clock (receiver oversampling clock)
//   reset                 : asynchronous active-high reset
//   rx_interrupt          : level interrupt from the receiver
//   rx_data, rx_err       : received byte and {parity, framing, overrun}
//   rx_ack                : registered acknowledge pulse, ACK_CYCLES wide
//   host_data, host_err   : FIFO head entry
//   host_valid/host_ready : host handshake; pop on valid & ready
//   fifo_level            : FIFO occupancy
//   stall                 : interrupt pending while the FIFO is full
//   ack_timeout           : sticky, receiver failed to drop its interrupt
// Build option RX_ERR_CNT_EN adds saturating parity_cnt / overrun_cnt outputs.
module uart_rx_host_ctrl
  import uart_rx_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned ACK_CYCLES  = 2,
  parameter int unsigned REL_TIMEOUT = 8
) (
  input  logic                       overSampler,
  input  logic                       reset,
  input  logic                       rx_interrupt,
  input  logic [7:0]                 rx_data,
  input  logic [2:0]                 rx_err,
  output logic                       rx_ack,
  output logic [7:0]                 host_data,
  output logic [2:0]                 host_err,
  output logic                       host_valid,
  input  logic                       host_ready,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic                       stall,
  output logic                       ack_timeout
`ifdef RX_ERR_CNT_EN
  ,
  output logic [7:0]                 parity_cnt,
  output logic [7:0]                 overrun_cnt
`endif
);

  localparam logic [3:0] AckLast = 4'(ACK_CYCLES - 1);
  localparam logic [7:0] RelLast = 8'(REL_TIMEOUT - 1);

  rx_state_e          state_q, state_d;
  logic [3:0]         ack_cnt_q, ack_cnt_d;
  logic [7:0]         rel_cnt_q, rel_cnt_d;
  logic               timeout_q, timeout_d;
  logic               rx_ack_q;
  logic               push;
  logic               fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] head;

  rx_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (overSampler),
    .reset (reset),
    .push  (push),
    .wdata ({rx_err, rx_data}),
    .pop   (host_ready),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    state_d   = state_q;
    ack_cnt_d = ack_cnt_q;
    rel_cnt_d = rel_cnt_q;
    timeout_d = timeout_q;
    push      = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Full is the registered flag, so a same-cycle pop cannot unblock this push.
        if (rx_interrupt && !fifo_full) begin
          push      = 1'b1;
          state_d   = StAck;
          ack_cnt_d = '0;
        end
      end
      StAck: begin
        if (ack_cnt_q == AckLast) begin
          state_d   = StRelease;
          ack_cnt_d = '0;
          rel_cnt_d = '0;
        end else begin
          ack_cnt_d = ack_cnt_q + 1'b1;
        end
      end
      StRelease: begin
        if (!rx_interrupt) begin
          state_d = StIdle;
        end else if (rel_cnt_q == RelLast) begin
          // Receiver missed the ack: pulse again without capturing a duplicate.
          timeout_d = 1'b1;
          state_d   = StAck;
          ack_cnt_d = '0;
          rel_cnt_d = '0;
        end else begin
          rel_cnt_d = rel_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge overSampler or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      ack_cnt_q <= '0;
      rel_cnt_q <= '0;
      timeout_q <= 1'b0;
      rx_ack_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ack_cnt_q <= ack_cnt_d;
      rel_cnt_q <= rel_cnt_d;
      timeout_q <= timeout_d;
      rx_ack_q  <= (state_d == StAck);
    end
  end

  assign rx_ack      = rx_ack_q;
  assign ack_timeout = timeout_q;
  assign stall       = (state_q == StIdle) & rx_interrupt & fifo_full;
  assign host_valid  = ~fifo_empty;
  assign host_data   = head[7:0];
  assign host_err    = head[10:8];

`ifdef RX_ERR_CNT_EN
  logic [7:0] parity_cnt_q, overrun_cnt_q;

  always_ff @(posedge overSampler or posedge reset) begin
    if (reset) begin
      parity_cnt_q  <= '0;
      overrun_cnt_q <= '0;
    end else if (push) begin
      if (rx_err[ERR_PARITY] && parity_cnt_q != 8'hFF) begin
        parity_cnt_q <= parity_cnt_q + 1'b1;
      end
      if (rx_err[ERR_OVERRUN] && overrun_cnt_q != 8'hFF) begin
        overrun_cnt_q <= overrun_cnt_q + 1'b1;
      end
    end
  end

  assign parity_cnt  = parity_cnt_q;
  assign overrun_cnt = overrun_cnt_q;
`else
  // Error counters not built; rx_err is only stored alongside each byte.
`endif

endmodule

// File: tb/tb_uart_rx_host_ctrl.sv
// Bench for uart_rx_host_ctrl: directed stimulus, expected FIFO entries are
// queued at issue time and checked by a monitor whenever the host pops.
module tb_uart_rx_host_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_interrupt = 1'b0;
  logic [7:0] rx_data = '0;
  logic [2:0] rx_err = '0;
  logic       host_ready = 1'b0;
  logic       rx_ack;
  logic [7:0] host_data;
  logic [2:0] host_err;
  logic       host_valid;
  logic [2:0] fifo_level;
  logic       stall;
  logic       ack_timeout;
`ifdef RX_ERR_CNT_EN
  logic [7:0] parity_cnt, overrun_cnt;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [10:0] exp_q[$];
  logic [10:0] mon_e;
  bit          track_max = 1'b0;
  int          max_level = 0;

  uart_rx_host_ctrl #(
    .DEPTH       (4),
    .ACK_CYCLES  (2),
    .REL_TIMEOUT (8)
  ) dut (
    .overSampler  (clk),
    .reset        (reset),
    .rx_interrupt (rx_interrupt),
    .rx_data      (rx_data),
    .rx_err       (rx_err),
    .rx_ack       (rx_ack),
    .host_data    (host_data),
    .host_err     (host_err),
    .host_valid   (host_valid),
    .host_ready   (host_ready),
    .fifo_level   (fifo_level),
    .stall        (stall),
    .ack_timeout  (ack_timeout)
`ifdef RX_ERR_CNT_EN
    ,
    .parity_cnt   (parity_cnt),
    .overrun_cnt  (overrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every accepted host transfer must match the queue head.
  always @(negedge clk) begin
    if (!reset && host_valid && host_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected actual=%0h required=none", host_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pop_data", 32'(host_data), 32'(mon_e[7:0]));
        chk("pop_err", 32'(host_err), 32'(mon_e[10:8]));
      end
    end
    if (track_max && int'(fifo_level) > max_level) max_level = int'(fifo_level);
  end

  task automatic wait_ack(input logic lvl, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (rx_ack !== lvl && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (rx_ack !== lvl) begin
      checks++;
      errors++;
      $display("FAIL %s actual=timeout required=rx_ack==%0b", name, lvl);
    end
  endtask

  // Receiver model: hold the interrupt until acked, then drop it.
  task automatic send(input logic [7:0] d, input logic [2:0] e);
    @(posedge clk); #1;
    rx_data = d;
    rx_err = e;
    rx_interrupt = 1'b1;
    exp_q.push_back({e, d});
    wait_ack(1'b1, "ack_rise");
    @(posedge clk); #1;
    rx_interrupt = 1'b0;
    wait_ack(1'b0, "ack_fall");
  endtask

  task automatic pop_one();
    @(posedge clk); #1;
    host_ready = 1'b1;
    @(posedge clk); #1;
    host_ready = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(posedge clk); #1;
    host_ready = 1'b1;
    @(negedge clk);
    while (host_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 32'(host_valid), 32'd0);
    @(posedge clk); #1;
    host_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=stuck required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ack", 32'(rx_ack), 32'd0);
    chk("rst_valid", 32'(host_valid), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_timeout", 32'(ack_timeout), 32'd0);
    chk("rst_data", 32'(host_data), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single byte with exact ack timing
    @(posedge clk); #1;
    rx_data = 8'hA5;
    rx_err = 3'b000;
    rx_interrupt = 1'b1;
    exp_q.push_back({3'b000, 8'hA5});
    @(negedge clk);
    chk("single_ack_c1", 32'(rx_ack), 32'd0);
    chk("single_valid_c1", 32'(host_valid), 32'd0);
    @(negedge clk);
    chk("single_ack_c2", 32'(rx_ack), 32'd1);
    chk("single_valid_c2", 32'(host_valid), 32'd1);
    chk("single_level", 32'(fifo_level), 32'd1);
    chk("single_data", 32'(host_data), 32'hA5);
    @(posedge clk); #1;
    rx_interrupt = 1'b0;
    @(negedge clk);
    chk("single_ack_c3", 32'(rx_ack), 32'd1);
    @(negedge clk);
    chk("single_ack_c4", 32'(rx_ack), 32'd0);
    pop_one();
    @(negedge clk);
    chk("single_valid_after_pop", 32'(host_valid), 32'd0);
    chk("single_data_empty", 32'(host_data), 32'd0);

    // Parity error passthrough
    send(8'h07, 3'b100);
    @(negedge clk);
    chk("parity_err", 32'(host_err), 32'b100);
`ifdef RX_ERR_CNT_EN
    chk("parity_cnt", 32'(parity_cnt), 32'd1);
`endif
    pop_one();

    // FIFO full: fifth interrupt stalls until a pop frees space
    send(8'h11, 3'b000);
    send(8'h22, 3'b001);
    send(8'h33, 3'b010);
    send(8'h44, 3'b111);
    @(negedge clk);
    chk("full_level", 32'(fifo_level), 32'd4);
    @(posedge clk); #1;
    rx_data = 8'h55;
    rx_err = 3'b000;
    rx_interrupt = 1'b1;
    exp_q.push_back({3'b000, 8'h55});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_stall", 32'(stall), 32'd1);
      chk("full_no_ack", 32'(rx_ack), 32'd0);
      chk("full_level_hold", 32'(fifo_level), 32'd4);
    end
    @(posedge clk); #1;
    host_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    host_ready = 1'b0;
    @(negedge clk);
    chk("unstall_stall", 32'(stall), 32'd0);
    chk("unstall_no_ack_yet", 32'(rx_ack), 32'd0);
    chk("unstall_level", 32'(fifo_level), 32'd3);
    @(negedge clk);
    chk("unstall_ack", 32'(rx_ack), 32'd1);
    chk("unstall_level_refill", 32'(fifo_level), 32'd4);
    @(posedge clk); #1;
    rx_interrupt = 1'b0;
    wait_ack(1'b0, "unstall_ack_fall");
    drain();

    // Release timeout: interrupt held after ack
    @(posedge clk); #1;
    rx_data = 8'h66;
    rx_err = 3'b010;
    rx_interrupt = 1'b1;
    exp_q.push_back({3'b010, 8'h66});
    wait_ack(1'b1, "to_ack_rise");
    chk("to_level", 32'(fifo_level), 32'd1);
    wait_ack(1'b0, "to_ack_fall");
    repeat (7) @(negedge clk);
    chk("to_before_ack", 32'(rx_ack), 32'd0);
    chk("to_before_flag", 32'(ack_timeout), 32'd0);
    @(negedge clk);
    chk("to_reack", 32'(rx_ack), 32'd1);
    chk("to_flag", 32'(ack_timeout), 32'd1);
    chk("to_no_dup", 32'(fifo_level), 32'd1);
    @(posedge clk); #1;
    rx_interrupt = 1'b0;
    wait_ack(1'b0, "to_reack_fall");
    @(negedge clk);
    chk("to_level_after", 32'(fifo_level), 32'd1);
    chk("to_sticky", 32'(ack_timeout), 32'd1);
    drain();

    // Back-to-back with the host always ready
    @(posedge clk); #1;
    host_ready = 1'b1;
    max_level = 0;
    track_max = 1'b1;
    send(8'h01, 3'b000);
    send(8'h80, 3'b001);
    send(8'hFF, 3'b100);
    send(8'h3C, 3'b000);
    send(8'hC3, 3'b010);
    send(8'h5A, 3'b101);
    repeat (3) @(negedge clk);
    track_max = 1'b0;
    @(posedge clk); #1;
    host_ready = 1'b0;
    chk("b2b_max_level", 32'(max_level), 32'd1);
    chk("b2b_drained", 32'(exp_q.size()), 32'd0);

    // Reset during the first ACK cycle
    @(posedge clk); #1;
    rx_data = 8'h77;
    rx_err = 3'b001;
    rx_interrupt = 1'b1;
    wait_ack(1'b1, "rst_mid_ack_rise");
    #2;
    reset = 1'b1;
    rx_interrupt = 1'b0;
    #1;
    chk("rst_mid_ack", 32'(rx_ack), 32'd0);
    chk("rst_mid_level", 32'(fifo_level), 32'd0);
    chk("rst_mid_valid", 32'(host_valid), 32'd0);
    chk("rst_mid_timeout", 32'(ack_timeout), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    send(8'h88, 3'b011);
    @(negedge clk);
    chk("post_rst_level", 32'(fifo_level), 32'd1);
    chk("post_rst_data", 32'(host_data), 32'h88);
    drain();

    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_host_ctrl.md
Name: uart_rx_host_ctrl

Overview:
Host-side controller that sequences the UART byte receiver. It answers the receiver's interrupt, captures the byte and error flags into a small FIFO, and drives the acknowledge pulse back to the receiver. It presents the buffered bytes to the host processor through a valid/ready handshake. It runs on the receiver's oversampling clock and sits between the receiver and the host bus.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..16
ACK_CYCLES, 2, width of the rx_ack pulse in clock cycles; 1..15
REL_TIMEOUT, 8, cycles to wait for rx_interrupt to drop after ack before re-acking; 2..255

Ports:
overSampler  in  1  clock; all logic on its rising edge
reset  in  1  asynchronous, active-high reset
rx_interrupt  in  1  receiver interrupt (level, held until acknowledged)
rx_data  in  8  receiver data byte
rx_err  in  3  receiver error flags {parity, framing, overrun}
rx_ack  out  1  acknowledge pulse to receiver (registered)
host_data  out  8  byte at FIFO head
host_err  out  3  error flags stored with head byte
host_valid  out  1  FIFO not empty
host_ready  in  1  host consumes head when host_valid & host_ready
fifo_level  out  $clog2(DEPTH+1)  current occupancy
stall  out  1  receiver byte pending but FIFO full
ack_timeout  out  1  sticky: a REL_TIMEOUT expiry occurred; cleared only by reset

Behaviour:
- Reset (async, active-high): FSM=IDLE, FIFO empty, counters 0; all outputs 0 (host_data/host_err 0 while empty). rx_ack drops immediately, including mid-pulse.
- FSM states: IDLE, ACK, RELEASE.
- IDLE, rx_interrupt=1, FIFO not full: on that edge write {rx_err,rx_data} to the FIFO tail and go to ACK. Exactly one write per interrupt.
- IDLE, rx_interrupt=1, FIFO full: no write, no ack. stall=1 (combinational) until space frees. The receiver then reports overrun itself; this block does not drop or overwrite.
- Full is evaluated before the same-cycle pop. A pop and a blocked push in one cycle means the push happens on the next cycle.
- ACK: rx_ack=1 for exactly ACK_CYCLES cycles, then go to RELEASE with rx_ack=0. rx_ack is registered, so it rises 1 cycle after the capture edge.
- RELEASE: when rx_interrupt=0, go to IDLE. If rx_interrupt is still 1 after REL_TIMEOUT cycles, set ack_timeout and return to ACK (re-pulse). No new capture occurs.
- Latency: capture edge to host_valid=1 is 1 cycle (registered FIFO count). Minimum spacing between captures is ACK_CYCLES+2 cycles.
- Host side: host_valid=(level!=0). host_data/host_err show the head entry combinationally from the registered read pointer. Pop when host_valid & host_ready; pop while empty is ignored.
- Push and pop in the same cycle when not full and not empty: level unchanged.
- Pointers wrap modulo DEPTH. fifo_level saturates at DEPTH by construction.
- rx_err is passed through unchanged; framing bit stored as received.

Optional Feature:
RX_ERR_CNT_EN. When defined, add outputs parity_cnt[7:0] and overrun_cnt[7:0]. Each increments once per captured byte whose rx_err[2] / rx_err[0] is set and saturates at 255. Reset clears both. When undefined, these ports and their logic are absent and behaviour is otherwise identical.

Decomposition:
- Package uart_rx_pkg: FSM state enum (IDLE, ACK, RELEASE), error bit indices (ERR_PARITY=2, ERR_FRAMING=1, ERR_OVERRUN=0), FIFO entry width 11.
- Sub-module rx_byte_fifo: DEPTH x 11-bit synchronous FIFO with full, empty and level. The FSM, ack timing and counters stay in the top module.

Test Plan:
- Reset mid-ACK: assert reset during ACK cycle 1 -> rx_ack=0 immediately, fifo_level=0, FSM IDLE; after release, a new interrupt is captured normally.
- Single byte: rx_interrupt=1, rx_data=0xA5, rx_err=0 -> one write; rx_ack high cycles 2..3 (ACK_CYCLES=2); host_valid=1, host_data=0xA5; host_ready=1 -> host_valid=0.
- Parity error: rx_data=0x07, rx_err=3'b100 -> host_err=3'b100; with RX_ERR_CNT_EN, parity_cnt=1.
- FIFO full: 4 bytes captured, host_ready=0, 5th interrupt -> stall=1, no rx_ack, level=4. Pop one -> next cycle 5th byte captured, stall=0, ack follows.
- Release timeout: hold rx_interrupt=1 after ack -> after 8 cycles ack_timeout=1 and rx_ack re-pulses; fifo_level stays 1 (no duplicate).
- Back-to-back: 6 bytes with host_ready=1 continuously -> bytes read in order, no loss, level never exceeds 1.
